// File: rtl/debouncer_multi_if.sv
// +----------------------------------------------------------------------+
// | debouncer_multi_if : control/status bundle for debouncer_multi        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface debouncer_multi_if #(
  parameter int NUM_CH = 4
);
  logic              en;
  logic [NUM_CH-1:0] noisy_in;
  logic [NUM_CH-1:0] debouncer_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] busy;

  modport master (
    output en, noisy_in,
    input  debouncer_out, rise_pulse, fall_pulse, busy
  );

  modport slave (
    input  en, noisy_in,
    output debouncer_out, rise_pulse, fall_pulse, busy
  );
endinterface

`default_nettype wire

// File: rtl/debouncer_multi.sv
// +----------------------------------------------------------------------+
// | debouncer_multi : per-channel synchroniser + stability-count FSM      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module debouncer_multi #(
  parameter int NUM_CH      = 4,
  parameter int NUM_STAGES  = 2,
  parameter int COUNT_FINAL = 99
) (
  input  wire logic             clk,
  input  wire logic             rst,
  debouncer_multi_if.slave      bus
);

  localparam int                 c_cnt_w     = $clog2(COUNT_FINAL + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_final = c_cnt_w'(COUNT_FINAL);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_WAIT_HIGH   = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_WAIT_LOW    = 2'd3
  } state_t;

  logic [NUM_CH-1:0] w_out;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_busy;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [NUM_STAGES-1:0] r_sync;
      logic                  w_s;
      state_t                r_state;
      state_t                w_state_nxt;
      logic [c_cnt_w-1:0]    r_cnt;
      logic [c_cnt_w-1:0]    w_cnt_nxt;
      logic                  r_out;
      logic                  w_out_nxt;
      logic                  r_rise;
      logic                  w_rise_nxt;
      logic                  r_fall;
      logic                  w_fall_nxt;
      logic                  r_busy;

      // Synchroniser keeps shifting regardless of en.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[NUM_STAGES-2:0], bus.noisy_in[g]};
        end
      end

      assign w_s = r_sync[NUM_STAGES-1];

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (bus.en) begin
          case (r_state)
            ST_STABLE_LOW: begin
              if (w_s) begin
                w_state_nxt = ST_WAIT_HIGH;
                w_cnt_nxt   = '0;
              end
            end
            // A revert on the terminal-count edge wins over the transition.
            ST_WAIT_HIGH: begin
              if (!w_s) begin
                w_state_nxt = ST_STABLE_LOW;
                w_cnt_nxt   = '0;
              end else if (r_cnt == c_cnt_final) begin
                w_state_nxt = ST_STABLE_HIGH;
                w_out_nxt   = 1'b1;
                w_rise_nxt  = 1'b1;
              end else begin
                w_cnt_nxt = r_cnt + c_cnt_one;
              end
            end
            ST_STABLE_HIGH: begin
              if (!w_s) begin
                w_state_nxt = ST_WAIT_LOW;
                w_cnt_nxt   = '0;
              end
            end
            ST_WAIT_LOW: begin
              if (w_s) begin
                w_state_nxt = ST_STABLE_HIGH;
                w_cnt_nxt   = '0;
              end else if (r_cnt == c_cnt_final) begin
                w_state_nxt = ST_STABLE_LOW;
                w_out_nxt   = 1'b0;
                w_fall_nxt  = 1'b1;
              end else begin
                w_cnt_nxt = r_cnt + c_cnt_one;
              end
            end
            default: begin
              w_state_nxt = ST_STABLE_LOW;
              w_cnt_nxt   = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_STABLE_LOW;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_out   <= w_out_nxt;
          r_rise  <= w_rise_nxt;
          r_fall  <= w_fall_nxt;
          r_busy  <= (w_state_nxt == ST_WAIT_HIGH) || (w_state_nxt == ST_WAIT_LOW);
        end
      end

      assign w_out[g]  = r_out;
      assign w_rise[g] = r_rise;
      assign w_fall[g] = r_fall;
      assign w_busy[g] = r_busy;
    end
  endgenerate

  assign bus.debouncer_out = w_out;
  assign bus.rise_pulse    = w_rise;
  assign bus.fall_pulse    = w_fall;
  assign bus.busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_debouncer_multi.sv
// +----------------------------------------------------------------------+
// | tb_debouncer_multi : directed vector bench for debouncer_multi        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_debouncer_multi;

  logic clk;
  logic rst;

  debouncer_multi_if #(.NUM_CH(4)) bus ();

  debouncer_multi #(
    .NUM_CH      (4),
    .NUM_STAGES  (2),
    .COUNT_FINAL (99)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic       en;
    int         cyc;
    logic [3:0] out;
    logic [3:0] busy;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs [15];
  int   n_pass;
  int   n_total;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Steps n edges, counting cycles on which any pulse is seen.
  task automatic quiet(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      step(1);
      if ((bus.rise_pulse | bus.fall_pulse) != 4'b0000) bad++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.noisy_in = 4'b0000;
    bus.en = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int          bad;
    logic [5:0]  seq;
    logic [3:0]  e_busy;
    logic [3:0]  e_out;
    logic [3:0]  e_rise;
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.noisy_in = 4'b0000;

    // Vectors on channel 3; cyc = edges advanced after applying inputs.
    vecs[0]  = '{4'b0000, 1'b1,   4, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1000, 1'b1,   2, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b1000, 1'b1,   1, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b1000, 1'b1,  99, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b1000, 1'b1,   1, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
    vecs[5]  = '{4'b1000, 1'b1,   1, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b1000, 1'b1,  20, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0000, 1'b1,   3, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0000, 1'b1,  99, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b0000, 1'b1,   1, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    vecs[10] = '{4'b0000, 1'b1,   1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b1000, 1'b0, 150, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[12] = '{4'b1000, 1'b1,   1, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    vecs[13] = '{4'b1000, 1'b1,  99, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    vecs[14] = '{4'b1000, 1'b1,   1, 4'b1000, 4'b0000, 4'b1000, 4'b0000};

    step(2);
    chk("reset_out",  bus.debouncer_out, 4'b0000);
    chk("reset_busy", bus.busy,          4'b0000);
    chk("reset_rise", bus.rise_pulse,    4'b0000);
    chk("reset_fall", bus.fall_pulse,    4'b0000);
    rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      bus.noisy_in = vecs[v].in;
      bus.en       = vecs[v].en;
      step(vecs[v].cyc);
      chk($sformatf("vec%0d_out", v),  bus.debouncer_out, vecs[v].out);
      chk($sformatf("vec%0d_busy", v), bus.busy,          vecs[v].busy);
      chk($sformatf("vec%0d_rise", v), bus.rise_pulse,    vecs[v].rise);
      chk($sformatf("vec%0d_fall", v), bus.fall_pulse,    vecs[v].fall);
    end

    // Glitch train 1,0,1,1,0,1 on ch1, then steady high.
    do_reset();
    step(5);
    seq = 6'b101101;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      bus.noisy_in = {2'b00, seq[k], 1'b0};
      step(1);
      if ((bus.rise_pulse | bus.fall_pulse) != 4'b0000) bad++;
    end
    chk("glitch_train_pulses", 32'(bad), 32'd0);
    quiet(101, bad);
    chk("glitch_early_pulse", 32'(bad), 32'd0);
    chk("glitch_busy_before", bus.busy, 4'b0010);
    chk("glitch_out_before", bus.debouncer_out, 4'b0000);
    step(1);
    chk("glitch_rise", bus.rise_pulse, 4'b0010);
    chk("glitch_out",  bus.debouncer_out, 4'b0010);

    // en low for 20 cycles mid-count on ch0.
    do_reset();
    bus.noisy_in = 4'b0001;
    step(50);
    chk("en_busy_pre", bus.busy, 4'b0001);
    bus.en = 1'b0;
    quiet(20, bad);
    chk("en_low_pulses", 32'(bad), 32'd0);
    chk("en_low_busy", bus.busy, 4'b0001);
    bus.en = 1'b1;
    quiet(52, bad);
    chk("en_resume_early", 32'(bad), 32'd0);
    chk("en_resume_out_pre", bus.debouncer_out, 4'b0000);
    step(1);
    chk("en_delayed_rise", bus.rise_pulse, 4'b0001);

    // Async reset at count 50 on ch0 with ch2 already high.
    do_reset();
    bus.noisy_in = 4'b0100;
    step(103);
    chk("rst_setup_rise", bus.rise_pulse, 4'b0100);
    step(5);
    bus.noisy_in = 4'b0101;
    step(53);
    chk("rst_pre_busy", bus.busy, 4'b0001);
    chk("rst_pre_out",  bus.debouncer_out, 4'b0100);
    rst = 1'b1;
    #2;
    chk("rst_async_out",  bus.debouncer_out, 4'b0000);
    chk("rst_async_busy", bus.busy, 4'b0000);
    #1;
    rst = 1'b0;
    quiet(102, bad);
    chk("rst_release_early", 32'(bad), 32'd0);
    chk("rst_release_busy", bus.busy, 4'b0101);
    step(1);
    chk("rst_release_rise", bus.rise_pulse, 4'b0101);
    chk("rst_release_out",  bus.debouncer_out, 4'b0101);

    // Fall on ch0 with a 1-cycle high glitch during WAIT_LOW.
    bus.noisy_in = 4'b0100;
    step(3);
    chk("fall_wait_busy", bus.busy, 4'b0001);
    step(27);
    bus.noisy_in = 4'b0101;
    step(1);
    bus.noisy_in = 4'b0100;
    quiet(102, bad);
    chk("fall_glitch_early", 32'(bad), 32'd0);
    chk("fall_glitch_out_pre", bus.debouncer_out, 4'b0101);
    step(1);
    chk("fall_pulse", bus.fall_pulse, 4'b0001);
    chk("fall_out",   bus.debouncer_out, 4'b0100);
    step(1);
    chk("fall_pulse_clear", bus.fall_pulse, 4'b0000);

    // Staggered rises, channel i captured 10*i edges after channel 0.
    do_reset();
    for (int n = 0; n <= 140; n++) begin
      for (int i = 0; i < 4; i++) bus.noisy_in[i] = (n >= 10 * i);
      step(1);
      for (int i = 0; i < 4; i++) begin
        int rel;
        rel = n - 10 * i;
        e_busy[i] = (rel >= 2) && (rel <= 101);
        e_out[i]  = (rel >= 102);
        e_rise[i] = (rel == 102);
      end
      chk($sformatf("stag%0d_busy", n), bus.busy, e_busy);
      chk($sformatf("stag%0d_out", n),  bus.debouncer_out, e_out);
      chk($sformatf("stag%0d_rise", n), bus.rise_pulse, e_rise);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
